pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives the write-enable and flush (bubble) controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Handles load-use hazards, taken-branch squashes, multi-cycle EX operations and data-memory wait states.
- Flags a data-memory timeout and keeps a stall-cycle performance counter.

Parameters:
- MEM_TIMEOUT, 1023: maximum consecutive MEM_WAIT cycles before HALT; counter width is clog2(MEM_TIMEOUT+1).
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk_i in 1: clock, rising edge.
- rst_i in 1: reset, asynchronous, active-low.
- ifid_rs1_i in 5: rs1 index of the instruction in IF/ID.
- ifid_rs2_i in 5: rs2 index of the instruction in IF/ID.
- ifid_uses_rs2_i in 1: IF/ID instruction reads rs2.
- idex_memread_i in 1: ID/EX holds a load.
- idex_rd_i in 5: ID/EX destination register.
- exe_branch_taken_i in 1: EX resolved a taken branch or jump.
- mc_start_i in 1: ID/EX holds a multi-cycle op in its first EX cycle.
- mc_done_i in 1: multi-cycle unit result valid.
- dmem_req_i in 1: MEM stage is accessing data memory.
- dmem_ready_i in 1: data memory completes the access this cycle.
- pc_write_o out 1: PC write enable.
- ifid_write_o, idex_write_o, exmem_write_o, memwb_write_o out 1 each: stage register write enables.
- ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o out 1 each: load a bubble (all control fields zero).
- state_o out 2: current FSM state.
- timeout_o out 1: sticky memory-timeout flag.
- stall_cnt_o out CNT_W: count of cycles with pc_write_o=0.

Behaviour:
- Reset (rst_i=0):
  - State RUN, timeout counter 0, timeout_o 0, stall_cnt_o 0.
  - All *_write_o forced 0 and all *_flush_o forced 1, combinationally, while rst_i is low.
- States (encoded in the package): RUN=0, MEM_WAIT=1, MC_WAIT=2, HALT=3. Outputs are Mealy, from state and current inputs, with zero latency.
- Load-use hazard (sub-module): idex_memread_i & idex_rd_i!=0 & (idex_rd_i==ifid_rs1_i | (ifid_uses_rs2_i & idex_rd_i==ifid_rs2_i)).
- RUN decode, first match wins; default is all writes 1, all flushes 0:
  1. dmem_req_i & !dmem_ready_i:
     - pc/ifid/idex/exmem writes 0.
     - memwb_flush_o=1.
     - Next state MEM_WAIT.
  2. mc_start_i:
     - pc/ifid/idex writes 0.
     - exmem_flush_o=1.
     - memwb_write_o=1.
     - If mc_done_i is also 1, the op is single-cycle: default outputs, stay in RUN. Otherwise next state MC_WAIT.
  3. exe_branch_taken_i:
     - pc_write_o=1, ifid_flush_o=1, idex_flush_o=1.
     - Any load-use hazard this cycle is ignored (the instruction in ID is squashed).
  4. Load-use: pc_write_o=0, ifid_write_o=0, idex_flush_o=1; single bubble, stay in RUN.
- MEM_WAIT:
  - While !dmem_ready_i: same outputs as RUN rule 1; timeout counter increments.
  - dmem_ready_i=1:
    - Outputs and next state equal the RUN decode with rule 1 masked.
    - Timeout counter clears.
  - Counter reaching MEM_TIMEOUT with ready still low: next state HALT, timeout_o set.
  - Ready arriving on the same cycle the counter reaches MEM_TIMEOUT wins: no timeout.
- MC_WAIT:
  - While !mc_done_i: same outputs as RUN rule 2.
  - mc_done_i=1: outputs and next state equal the RUN decode with rules 1 and 2 masked.
  - dmem_req_i is ignored (the MEM stage holds a bubble).
- HALT: all writes 0, all flushes 0; exit only via reset. timeout_o stays 1.
- stall_cnt_o: +1 on every clock with rst_i high and pc_write_o=0, HALT included; saturates at all-ones.
- Reset asserted mid-stall: state returns to RUN immediately and all counters clear.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - State encoding constants.
  - REG_IDX_W=5.
  - Bubble-control constant (all zero).
- One sub-module load_use_detect: purely combinational hazard compare, reusable by the forwarding unit.

Test Plan:
- Reset: hold rst_i=0 for 3 cycles -> all writes 0, all flushes 1, state_o=0, stall_cnt_o=0. Release -> writes 1, flushes 0.
- Load-use: idex_memread_i=1, idex_rd_i=5, ifid_rs2_i=5, ifid_uses_rs2_i=1 -> exactly one cycle with pc_write_o=0, ifid_write_o=0, idex_flush_o=1. With idex_rd_i=0 -> no stall.
- Branch plus load-use in the same cycle -> ifid_flush_o=1, idex_flush_o=1, pc_write_o=1, no stall.
- Memory wait: dmem_req_i=1 with ready low for 4 cycles, then high -> 4 freeze cycles with memwb_flush_o=1, advance on the 5th cycle, stall_cnt_o=4.
- Multi-cycle op: mc_start_i then mc_done_i after 6 cycles -> exmem_flush_o=1 for 6 cycles, state_o=2, then RUN. mc_start_i and mc_done_i together -> no stall.
- Timeout with MEM_TIMEOUT=8: dmem_ready_i never asserts -> state_o=3 and timeout_o=1 after 9 stalled cycles. Outputs frozen until rst_i low clears them.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM encoding,
// register-index width and the per-stage control bundle.
package pipe_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;

    // Control fields of a bubble loaded into a stage register.
    localparam int unsigned BUBBLE_CTRL_W = 16;
    localparam logic [BUBBLE_CTRL_W-1:0] BUBBLE_CTRL = '0;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StMcWait  = 2'd2,
        StHalt    = 2'd3
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic memwb_write;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
    } ctrl_t;

    localparam ctrl_t CtrlRun     = ctrl_t'(9'b1_1111_0000);
    localparam ctrl_t CtrlReset   = ctrl_t'(9'b0_0000_1111);
    localparam ctrl_t CtrlHalt    = ctrl_t'(9'b0_0000_0000);
    // Freeze PC..EX/MEM, push a bubble into MEM/WB.
    localparam ctrl_t CtrlMemHold = ctrl_t'(9'b0_0001_0001);
    // Freeze PC..ID/EX, bubble into EX/MEM, let MEM/WB drain.
    localparam ctrl_t CtrlMcHold  = ctrl_t'(9'b0_0011_0010);

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between ID/EX and IF/ID.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                 idex_memread_i,
    input  logic [REG_IDX_W-1:0] idex_rd_i,
    input  logic [REG_IDX_W-1:0] ifid_rs1_i,
    input  logic [REG_IDX_W-1:0] ifid_rs2_i,
    input  logic                 ifid_uses_rs2_i,
    output logic                 hazard_o
);

    always_comb begin
        hazard_o = idex_memread_i && (idex_rd_i != '0) &&
                   ((idex_rd_i == ifid_rs1_i) ||
                    (ifid_uses_rs2_i && (idex_rd_i == ifid_rs2_i)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch squash,
// multi-cycle EX and data-memory wait handling with timeout and stall counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 1023,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [REG_IDX_W-1:0] ifid_rs1_i,
    input  logic [REG_IDX_W-1:0] ifid_rs2_i,
    input  logic                 ifid_uses_rs2_i,
    input  logic                 idex_memread_i,
    input  logic [REG_IDX_W-1:0] idex_rd_i,
    input  logic                 exe_branch_taken_i,
    input  logic                 mc_start_i,
    input  logic                 mc_done_i,
    input  logic                 dmem_req_i,
    input  logic                 dmem_ready_i,
    output logic                 pc_write_o,
    output logic                 ifid_write_o,
    output logic                 idex_write_o,
    output logic                 exmem_write_o,
    output logic                 memwb_write_o,
    output logic                 ifid_flush_o,
    output logic                 idex_flush_o,
    output logic                 exmem_flush_o,
    output logic                 memwb_flush_o,
    output logic [1:0]           state_o,
    output logic                 timeout_o,
    output logic [CNT_W-1:0]     stall_cnt_o
);

    localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              load_use;
    logic              run_dec, mask_mem, mask_mc;
    ctrl_t             ctrl, ctrl_out;

    load_use_detect u_load_use_detect (
        .idex_memread_i  (idex_memread_i),
        .idex_rd_i       (idex_rd_i),
        .ifid_rs1_i      (ifid_rs1_i),
        .ifid_rs2_i      (ifid_rs2_i),
        .ifid_uses_rs2_i (ifid_uses_rs2_i),
        .hazard_o        (load_use)
    );

    always_comb begin
        ctrl      = CtrlRun;
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout_q;
        run_dec   = 1'b0;
        mask_mem  = 1'b0;
        mask_mc   = 1'b0;

        unique case (state_q)
            StRun: run_dec = 1'b1;
            StMemWait: begin
                if (!dmem_ready_i) begin
                    ctrl     = CtrlMemHold;
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (to_cnt_q == TO_W'(MEM_TIMEOUT - 1)) begin
                        state_d   = StHalt;
                        timeout_d = 1'b1;
                    end
                end else begin
                    run_dec  = 1'b1;
                    mask_mem = 1'b1;
                    to_cnt_d = '0;
                end
            end
            StMcWait: begin
                if (!mc_done_i) begin
                    ctrl = CtrlMcHold;
                end else begin
                    // The MEM stage holds a bubble here, so dmem_req_i is stale.
                    run_dec  = 1'b1;
                    mask_mem = 1'b1;
                    mask_mc  = 1'b1;
                end
            end
            StHalt: ctrl = CtrlHalt;
            default: ctrl = CtrlHalt;
        endcase

        if (run_dec) begin
            state_d = StRun;
            if (!mask_mem && dmem_req_i && !dmem_ready_i) begin
                ctrl    = CtrlMemHold;
                state_d = StMemWait;
            end else if (!mask_mc && mc_start_i) begin
                // A start with done already high is a single-cycle op: no stall.
                if (!mc_done_i) begin
                    ctrl    = CtrlMcHold;
                    state_d = StMcWait;
                end
            end else if (exe_branch_taken_i) begin
                ctrl.ifid_flush = 1'b1;
                ctrl.idex_flush = 1'b1;
            end else if (load_use) begin
                ctrl.pc_write   = 1'b0;
                ctrl.ifid_write = 1'b0;
                ctrl.idex_flush = 1'b1;
            end
        end

        ctrl_out = rst_i ? ctrl : CtrlReset;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StRun;
            to_cnt_q    <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
            if (!ctrl_out.pc_write && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign pc_write_o    = ctrl_out.pc_write;
    assign ifid_write_o  = ctrl_out.ifid_write;
    assign idex_write_o  = ctrl_out.idex_write;
    assign exmem_write_o = ctrl_out.exmem_write;
    assign memwb_write_o = ctrl_out.memwb_write;
    assign ifid_flush_o  = ctrl_out.ifid_flush;
    assign idex_flush_o  = ctrl_out.idex_flush;
    assign exmem_flush_o = ctrl_out.exmem_flush;
    assign memwb_flush_o = ctrl_out.memwb_flush;
    assign state_o       = state_q;
    assign timeout_o     = timeout_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MEM_TIMEOUT=8 and hand-computed expectations.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  ifid_rs1, ifid_rs2, idex_rd;
    logic        ifid_uses_rs2, idex_memread, branch_taken;
    logic        mc_start, mc_done, dmem_req, dmem_ready;
    logic        pc_write, ifid_write, idex_write, exmem_write, memwb_write;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic [1:0]  state;
    logic        timeout;
    logic [31:0] stall_cnt;

    logic [4:0]  wr;
    logic [3:0]  fl;
    int          n_checks;
    int          n_errors;

    assign wr = {pc_write, ifid_write, idex_write, exmem_write, memwb_write};
    assign fl = {ifid_flush, idex_flush, exmem_flush, memwb_flush};

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (8),
        .CNT_W       (32)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .ifid_rs1_i         (ifid_rs1),
        .ifid_rs2_i         (ifid_rs2),
        .ifid_uses_rs2_i    (ifid_uses_rs2),
        .idex_memread_i     (idex_memread),
        .idex_rd_i          (idex_rd),
        .exe_branch_taken_i (branch_taken),
        .mc_start_i         (mc_start),
        .mc_done_i          (mc_done),
        .dmem_req_i         (dmem_req),
        .dmem_ready_i       (dmem_ready),
        .pc_write_o         (pc_write),
        .ifid_write_o       (ifid_write),
        .idex_write_o       (idex_write),
        .exmem_write_o      (exmem_write),
        .memwb_write_o      (memwb_write),
        .ifid_flush_o       (ifid_flush),
        .idex_flush_o       (idex_flush),
        .exmem_flush_o      (exmem_flush),
        .memwb_flush_o      (memwb_flush),
        .state_o            (state),
        .timeout_o          (timeout),
        .stall_cnt_o        (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs may change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifid_rs1      = 5'd0;
        ifid_rs2      = 5'd0;
        ifid_uses_rs2 = 1'b0;
        idex_memread  = 1'b0;
        idex_rd       = 5'd0;
        branch_taken  = 1'b0;
        mc_start      = 1'b0;
        mc_done       = 1'b0;
        dmem_req      = 1'b0;
        dmem_ready    = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        rst = 1'b0;

        // Reset held for 3 cycles.
        repeat (3) tick();
        check("rst_wr", 32'(wr), 32'h00);
        check("rst_fl", 32'(fl), 32'hf);
        check("rst_state", 32'(state), 32'd0);
        check("rst_stall", stall_cnt, 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        rst = 1'b1;
        #1;
        check("run_wr", 32'(wr), 32'h1f);
        check("run_fl", 32'(fl), 32'h0);

        // Load-use on rs2: one bubble cycle.
        idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs2 = 5'd5; ifid_uses_rs2 = 1'b1;
        ifid_rs1 = 5'd1;
        #1;
        check("lu_wr", 32'(wr), 32'h07);
        check("lu_fl", 32'(fl), 32'h4);
        tick();
        idex_memread = 1'b0;
        #1;
        check("lu_after_wr", 32'(wr), 32'h1f);
        check("lu_after_state", 32'(state), 32'd0);
        check("lu_stall", stall_cnt, 32'd1);

        // rd=0 never stalls, even with rs1=0.
        idex_memread = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0;
        #1;
        check("lu_x0_wr", 32'(wr), 32'h1f);
        // rs2 match ignored when rs2 is not read.
        idex_rd = 5'd7; ifid_rs2 = 5'd7; ifid_uses_rs2 = 1'b0; ifid_rs1 = 5'd3;
        #1;
        check("lu_nors2_wr", 32'(wr), 32'h1f);

        // Branch plus load-use: squash wins, no stall.
        idex_rd = 5'd5; ifid_rs1 = 5'd5; branch_taken = 1'b1;
        #1;
        check("br_wr", 32'(wr), 32'h1f);
        check("br_fl", 32'(fl), 32'hc);
        tick();
        idle_inputs();
        #1;
        check("br_stall", stall_cnt, 32'd1);

        // Memory wait: 4 frozen cycles, then ready.
        dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("mw_wr", 32'(wr), 32'h01);
            check("mw_fl", 32'(fl), 32'h1);
            check("mw_state", 32'(state), (i == 0) ? 32'd0 : 32'd1);
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        check("mw_rdy_wr", 32'(wr), 32'h1f);
        check("mw_rdy_fl", 32'(fl), 32'h0);
        tick();
        idle_inputs();
        #1;
        check("mw_end_state", 32'(state), 32'd0);
        check("mw_stall", stall_cnt, 32'd5);

        // Multi-cycle op: done arrives in the 7th cycle; MEM requests ignored meanwhile.
        mc_start = 1'b1;
        #1;
        check("mc_wr", 32'(wr), 32'h03);
        check("mc_fl", 32'(fl), 32'h2);
        tick();
        mc_start = 1'b0;
        dmem_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("mc_wait_state", 32'(state), 32'd2);
            check("mc_wait_fl", 32'(fl), 32'h2);
            check("mc_wait_wr", 32'(wr), 32'h03);
            tick();
        end
        mc_done = 1'b1;
        #1;
        check("mc_done_wr", 32'(wr), 32'h1f);
        check("mc_done_fl", 32'(fl), 32'h0);
        tick();
        idle_inputs();
        #1;
        check("mc_end_state", 32'(state), 32'd0);
        check("mc_stall", stall_cnt, 32'd11);

        // Single-cycle multi-cycle op.
        mc_start = 1'b1; mc_done = 1'b1;
        #1;
        check("mc1_wr", 32'(wr), 32'h1f);
        tick();
        idle_inputs();
        #1;
        check("mc1_state", 32'(state), 32'd0);
        check("mc1_stall", stall_cnt, 32'd11);

        // Ready arrives exactly as the timeout counter would hit the limit.
        dmem_req = 1'b1;
        repeat (8) tick();
        dmem_ready = 1'b1;
        #1;
        check("edge_state", 32'(state), 32'd1);
        check("edge_wr", 32'(wr), 32'h1f);
        tick();
        idle_inputs();
        #1;
        check("edge_end_state", 32'(state), 32'd0);
        check("edge_timeout", 32'(timeout), 32'd0);
        check("edge_stall", stall_cnt, 32'd19);

        // Timeout: ready never comes.
        dmem_req = 1'b1;
        repeat (8) tick();
        #1;
        check("pre_to_state", 32'(state), 32'd1);
        check("pre_to_timeout", 32'(timeout), 32'd0);
        tick();
        check("to_state", 32'(state), 32'd3);
        check("to_timeout", 32'(timeout), 32'd1);
        check("to_wr", 32'(wr), 32'h00);
        check("to_fl", 32'(fl), 32'h0);
        check("to_stall", stall_cnt, 32'd28);
        dmem_ready = 1'b1; mc_start = 1'b1; branch_taken = 1'b1;
        tick();
        check("halt_state", 32'(state), 32'd3);
        check("halt_timeout", 32'(timeout), 32'd1);
        check("halt_wr", 32'(wr), 32'h00);
        check("halt_stall", stall_cnt, 32'd29);

        // Reset out of HALT clears everything immediately.
        rst = 1'b0;
        #1;
        check("rst2_state", 32'(state), 32'd0);
        check("rst2_timeout", 32'(timeout), 32'd0);
        check("rst2_stall", stall_cnt, 32'd0);
        check("rst2_wr", 32'(wr), 32'h00);
        check("rst2_fl", 32'(fl), 32'hf);
        tick();
        idle_inputs();
        rst = 1'b1;
        #1;
        check("rst2_run_wr", 32'(wr), 32'h1f);
        check("rst2_run_fl", 32'(fl), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
